// File: rtl/imsic_pkg.sv
// Shared definitions for the IMSIC MSI transmitter and its cross-domain receiver.
//   msi_tx_state_e : transmitter FSM states (IDLE, HIGH, GUARD)
//   SETIPNUM_LSB / FILE_LSB / HART_LSB : field offsets inside MSI_INFO
//     for the default build (5-bit setipnum, 3-bit file). file_lsb() and
//     hart_lsb() give the same offsets for any other field widths.
package imsic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HIGH  = 2'd1,
        ST_GUARD = 2'd2
    } msi_tx_state_e;

    localparam int unsigned SETIPNUM_LSB        = 0;
    localparam int unsigned DEF_NR_SRC_WIDTH    = 5;
    localparam int unsigned DEF_INTP_FILE_WIDTH = 3;
    localparam int unsigned FILE_LSB            = SETIPNUM_LSB + DEF_NR_SRC_WIDTH;
    localparam int unsigned HART_LSB            = FILE_LSB + DEF_INTP_FILE_WIDTH;

    function automatic int unsigned file_lsb(input int unsigned src_w);
        return SETIPNUM_LSB + src_w;
    endfunction

    function automatic int unsigned hart_lsb(input int unsigned src_w,
                                             input int unsigned file_w);
        return SETIPNUM_LSB + src_w + file_w;
    endfunction

endpackage

// File: rtl/imsic_msi_tx_fifo.sv
// Synchronous FIFO queueing MSI_INFO words for imsic_msi_tx.
//   clk, rst     : clock, asynchronous active-high reset (empties the queue)
//   push, wdata  : write request / data
//   pop          : remove the head entry
//   rdata        : head entry (valid only when empty is low); a word written
//                  at an edge is visible from the following cycle only
//   full, empty  : occupancy flags
// A push while full is accepted when a pop happens in the same cycle.
module imsic_msi_tx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/imsic_msi_tx.sv
// IMSIC MSI transmitter: accepts MSI write requests, filters illegal ones,
// and emits each legal request as a registered {hart, file, setipnum} word
// with a VLD_HIGH_CYCLES strobe followed by VLD_GUARD_CYCLES of hold time so
// a receiver in another clock domain can capture it safely.
//   clk, rst        : clock, asynchronous active-high reset
//   i_msi_vld/o_msi_rdy : request handshake
//   i_msi_hart_id, i_msi_file, i_msi_setipnum : request fields
//   o_msi_info      : {hart_id, file, setipnum}, setipnum in the LSBs
//   o_msi_info_vld  : strobe to the receiver
//   o_busy          : transfer in progress or requests queued
//   o_drop_cnt      : saturating count of filtered requests
// Build option: define IMSIC_MSI_TX_FIFO_EN to queue requests in a
// FIFO_DEPTH-entry FIFO; otherwise requests are taken only while idle.
module imsic_msi_tx
    import imsic_pkg::*;
#(
    parameter int unsigned NR_HARTS_WIDTH   = 2,
    parameter int unsigned NR_INTP_FILES    = 7,
    parameter int unsigned NR_SRC           = 32,
    parameter int unsigned VLD_HIGH_CYCLES  = 4,
    parameter int unsigned VLD_GUARD_CYCLES = 8,
    parameter int unsigned FIFO_DEPTH       = 4,
    localparam int unsigned NR_SRC_WIDTH    = $clog2(NR_SRC),
    localparam int unsigned INTP_FILE_WIDTH = $clog2(NR_INTP_FILES),
    localparam int unsigned MSI_INFO_WIDTH  = NR_HARTS_WIDTH + INTP_FILE_WIDTH + NR_SRC_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_msi_vld,
    output logic                       o_msi_rdy,
    input  logic [NR_HARTS_WIDTH-1:0]  i_msi_hart_id,
    input  logic [INTP_FILE_WIDTH-1:0] i_msi_file,
    input  logic [NR_SRC_WIDTH-1:0]    i_msi_setipnum,
    output logic [MSI_INFO_WIDTH-1:0]  o_msi_info,
    output logic                       o_msi_info_vld,
    output logic                       o_busy,
    output logic [7:0]                 o_drop_cnt
);

    localparam int unsigned CNT_MAX = (VLD_HIGH_CYCLES > VLD_GUARD_CYCLES) ?
                                      VLD_HIGH_CYCLES : VLD_GUARD_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] HIGH_LOAD  = CNT_W'(VLD_HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(VLD_GUARD_CYCLES - 1);
    localparam int unsigned F_LSB = file_lsb(NR_SRC_WIDTH);
    localparam int unsigned H_LSB = hart_lsb(NR_SRC_WIDTH, INTP_FILE_WIDTH);

    msi_tx_state_e             state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [MSI_INFO_WIDTH-1:0] msi_info_q, msi_info_d;
    logic                      msi_vld_q, msi_vld_d;
    logic [7:0]                drop_cnt_q, drop_cnt_d;

    logic [MSI_INFO_WIDTH-1:0] req_info;
    logic                      req_ok;
    logic                      req_acc;
    logic                      src_vld;
    logic [MSI_INFO_WIDTH-1:0] src_info;
    logic                      load;
    logic                      queue_empty;

    always_comb begin
        req_info = '0;
        req_info[SETIPNUM_LSB +: NR_SRC_WIDTH] = i_msi_setipnum;
        req_info[F_LSB +: INTP_FILE_WIDTH]     = i_msi_file;
        req_info[H_LSB +: NR_HARTS_WIDTH]      = i_msi_hart_id;
    end

    // setipnum 0 is reserved (no interrupt), so the receiver ignores it too.
    assign req_ok = (i_msi_setipnum != '0) &&
                    (32'(i_msi_setipnum) < NR_SRC) &&
                    (32'(i_msi_file) < NR_INTP_FILES);

    assign req_acc = i_msi_vld && o_msi_rdy;

`ifdef IMSIC_MSI_TX_FIFO_EN
    logic fifo_full;

    imsic_msi_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (MSI_INFO_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (req_acc && req_ok),
        .wdata (req_info),
        .pop   (load),
        .rdata (src_info),
        .full  (fifo_full),
        .empty (queue_empty)
    );

    assign o_msi_rdy = !rst && !fifo_full;
    assign src_vld   = !queue_empty;
`else
    // Without a queue the request feeds the output register directly; the
    // handshake is only open while idle, so src_vld can only fire in IDLE.
    assign queue_empty = 1'b1;
    assign o_msi_rdy   = !rst && (state_q == ST_IDLE);
    assign src_vld     = req_acc && req_ok;
    assign src_info    = req_info;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        msi_info_d = msi_info_q;
        msi_vld_d  = msi_vld_q;
        load       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                load = src_vld;
            end
            ST_HIGH: begin
                if (cnt_q == '0) begin
                    state_d   = ST_GUARD;
                    msi_vld_d = 1'b0;
                    cnt_d     = GUARD_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_GUARD: begin
                // Guard expiry behaves as IDLE in the same cycle so a queued
                // request follows without a bubble.
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    load    = src_vld;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load) begin
            state_d    = ST_HIGH;
            msi_vld_d  = 1'b1;
            msi_info_d = src_info;
            cnt_d      = HIGH_LOAD;
        end
    end

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (req_acc && !req_ok && (drop_cnt_q != 8'hFF))
            drop_cnt_d = drop_cnt_q + 8'd1;
    end

    // Reset clears o_msi_info asynchronously so a receiver sampling during
    // reset sees setipnum 0 and discards it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            msi_info_q <= '0;
            msi_vld_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            msi_info_q <= msi_info_d;
            msi_vld_q  <= msi_vld_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign o_msi_info     = msi_info_q;
    assign o_msi_info_vld = msi_vld_q;
    assign o_drop_cnt     = drop_cnt_q;
    assign o_busy         = (state_q != ST_IDLE) || !queue_empty;

endmodule

// File: tb/tb_imsic_msi_tx.sv
// Self-checking bench for imsic_msi_tx (works with and without
// IMSIC_MSI_TX_FIFO_EN). A negedge monitor keeps a transaction-level model:
// expected MSI order, queue occupancy, strobe/hold window timing and the
// saturating drop count.
module tb_imsic_msi_tx;

    localparam int HIGH   = 4;
    localparam int GUARD  = 8;
    localparam int PERIOD = HIGH + GUARD;
    localparam int DEPTH  = 4;
`ifdef IMSIC_MSI_TX_FIFO_EN
    localparam bit FIFO_MODE = 1'b1;
    localparam int LAT       = 2;
    localparam int B2B_GAP   = PERIOD;
`else
    localparam bit FIFO_MODE = 1'b0;
    localparam int LAT       = 1;
    localparam int B2B_GAP   = PERIOD + 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_msi_vld = 1'b0;
    logic [1:0] hart = '0;
    logic [2:0] file = '0;
    logic [4:0] ip   = '0;
    logic       o_msi_rdy;
    logic [9:0] o_msi_info;
    logic       o_msi_info_vld;
    logic       o_busy;
    logic [7:0] o_drop_cnt;

    imsic_msi_tx #(
        .NR_HARTS_WIDTH   (2),
        .NR_INTP_FILES    (7),
        .NR_SRC           (32),
        .VLD_HIGH_CYCLES  (HIGH),
        .VLD_GUARD_CYCLES (GUARD),
        .FIFO_DEPTH       (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_msi_vld      (i_msi_vld),
        .o_msi_rdy      (o_msi_rdy),
        .i_msi_hart_id  (hart),
        .i_msi_file     (file),
        .i_msi_setipnum (ip),
        .o_msi_info     (o_msi_info),
        .o_msi_info_vld (o_msi_info_vld),
        .o_busy         (o_busy),
        .o_drop_cnt     (o_drop_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic [9:0] exp_q[$];
    int         rise_cyc[$];
    int         hs_cyc[$];
    int         occ = 0;
    int         age = 1000;
    int         cyc = 0;
    int         drop_model = 0;
    logic [9:0] last_info = '0;
    logic       prev_vld = 1'b0;
    logic       pend = 1'b0;
    logic       pend_ok = 1'b0;
    logic [9:0] pend_info = '0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            occ        = 0;
            age        = 1000;
            last_info  = '0;
            prev_vld   = 1'b0;
            pend       = 1'b0;
            drop_model = 0;
        end else begin
            // Handshake seen last negedge took effect at the edge in between.
            if (pend) begin
                if (pend_ok) begin
                    exp_q.push_back(pend_info);
                    occ++;
                end else if (drop_model < 255) begin
                    drop_model++;
                end
                pend = 1'b0;
            end
            if (age < 1000) age++;

            if (o_msi_info_vld && !prev_vld) begin
                rise_cyc.push_back(cyc);
                chk("rise_gap", 32'(age >= PERIOD), 32'd1);
                chk("msi_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    chk("msi_info_order", 32'(o_msi_info), 32'(exp_q[0]));
                    void'(exp_q.pop_front());
                    occ--;
                end
                last_info = o_msi_info;
                age = 0;
            end else begin
                chk("info_stable", 32'(o_msi_info), 32'(last_info));
            end

            chk("vld_window", 32'(o_msi_info_vld), 32'(age < HIGH));
            chk("drop_cnt", 32'(o_drop_cnt), drop_model);
            if (FIFO_MODE) chk("rdy_fifo", 32'(o_msi_rdy), 32'(occ != DEPTH));
            else           chk("rdy_idle", 32'(o_msi_rdy), 32'(age >= PERIOD));
            chk("busy", 32'(o_busy), 32'((age < PERIOD) || (occ > 0)));
            prev_vld = o_msi_info_vld;

            if (i_msi_vld && o_msi_rdy) begin
                pend      = 1'b1;
                pend_info = {hart, file, ip};
                pend_ok   = (ip != 5'd0) && (file < 3'd7);
                hs_cyc.push_back(cyc);
            end
        end
    end

    // ---------------- stimulus helpers (called at posedge+1) ----------------
    task automatic send(input logic [1:0] h, input logic [2:0] f, input logic [4:0] s);
        int n = 0;
        i_msi_vld = 1'b1;
        hart = h;
        file = f;
        ip   = s;
        @(negedge clk);
        while (!o_msi_rdy && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("send_timeout", 32'(n < 200), 32'd1);
        @(posedge clk);
        #1;
        i_msi_vld = 1'b0;
    endtask

    task automatic wait_drain(input int maxc);
        int n = 0;
        repeat (2) @(posedge clk);
        #1;
        while ((o_busy || exp_q.size() != 0 || pend) && n < maxc) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", 32'(n < maxc), 32'd1);
        chk("drain_all_emitted", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_rise(input int k, input int maxc);
        int n = 0;
        while (rise_cyc.size() < k && n < maxc) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("rise_timeout", 32'(rise_cyc.size() >= k), 32'd1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        i_msi_vld = 1'b0;
        #1;
        chk("rst_vld", 32'(o_msi_info_vld), 32'd0);
        chk("rst_info", 32'(o_msi_info), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_rdy", 32'(o_msi_rdy), 32'd0);
        chk("rst_drop", 32'(o_drop_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        rise_cyc.delete();
        hs_cyc.delete();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [1:0] rh;
        logic [2:0] rf;
        logic [4:0] rs;

        do_reset();

        // Single request {hart 1, file 1, setipnum 5}.
        clear_log();
        send(2'd1, 3'd1, 5'd5);
        wait_rise(1, 20);
        chk("single_info", 32'(o_msi_info), 32'(10'b01_001_00101));
        if (rise_cyc.size() > 0 && hs_cyc.size() > 0)
            chk("single_latency", rise_cyc[0] - hs_cyc[0], LAT);
        @(posedge clk);
        #1;
        wait_drain(100);
        chk("single_busy_clear", 32'(o_busy), 32'd0);

        // Five back-to-back requests.
        clear_log();
        for (int i = 0; i < 5; i++)
            send(2'(i), 3'(i + 1), 5'(3 * i + 2));
        wait_drain(300);
        chk("burst_count", 32'(rise_cyc.size()), 32'd5);
        if (rise_cyc.size() == 5) begin
            for (int i = 1; i < 5; i++)
                chk("burst_gap", rise_cyc[i] - rise_cyc[i-1], B2B_GAP);
            chk("burst_latency", rise_cyc[0] - hs_cyc[0], LAT);
        end

        // Filtered requests, then a valid one.
        do_reset();
        clear_log();
        send(2'd0, 3'd1, 5'd0);
        send(2'd2, 3'd7, 5'd3);
        send(2'd3, 3'd2, 5'd9);
        wait_drain(100);
        chk("drop_two", 32'(o_drop_cnt), 32'd2);
        chk("drop_emit_count", 32'(rise_cyc.size()), 32'd1);

        // Saturation after 300 drops.
        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 0) send(2'($urandom_range(0, 3)), 3'd7, 5'($urandom_range(0, 31)));
            else            send(2'($urandom_range(0, 3)), 3'($urandom_range(0, 6)), 5'd0);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("drop_saturate", 32'(o_drop_cnt), 32'd255);

        // Reset while the strobe is high, with more requests queued if possible.
        do_reset();
        clear_log();
        send(2'd2, 3'd3, 5'd17);
        if (FIFO_MODE) begin
            send(2'd1, 3'd0, 5'd4);
            send(2'd0, 3'd6, 5'd31);
        end
        wait_rise(1, 20);
        chk("pre_reset_vld", 32'(o_msi_info_vld), 32'd1);
        @(posedge clk);
        #1;
        do_reset();
        clear_log();
        send(2'd1, 3'd4, 5'd30);
        wait_drain(100);
        chk("post_reset_emit", 32'(rise_cyc.size()), 32'd1);

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            rh = 2'($urandom_range(0, 3));
            rf = 3'($urandom_range(0, 7));
            rs = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            send(rh, rf, rs);
        end
        wait_drain(2000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d checks=%0d)", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/imsic_msi_tx.md
IMSIC_MSI_TX -- requirements
Module: imsic_msi_tx

Interface
REQ-001 SHALL have parameter NR_HARTS_WIDTH, default 2, width of the target hart ID.
REQ-002 SHALL have parameter NR_INTP_FILES, default 7, number of files per hart (M, S, 5 VS).
REQ-003 SHALL have parameter NR_SRC, default 32, number of interrupt identities per file.
REQ-004 SHALL have parameter VLD_HIGH_CYCLES, default 4, number of cycles o_msi_info_vld stays high.
REQ-005 SHALL have parameter VLD_GUARD_CYCLES, default 8, number of cycles o_msi_info is held after o_msi_info_vld falls.
REQ-006 SHALL have parameter FIFO_DEPTH, default 4, a power of 2 and at least 2.
REQ-007 SHALL derive NR_SRC_WIDTH = $clog2(NR_SRC), INTP_FILE_WIDTH = $clog2(NR_INTP_FILES), and MSI_INFO_WIDTH = NR_HARTS_WIDTH + INTP_FILE_WIDTH + NR_SRC_WIDTH.
REQ-008 SHALL have port clk, input, 1 bit: the single clock.
REQ-009 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-010 SHALL have port i_msi_vld, input, 1 bit: MSI write request valid.
REQ-011 SHALL have port o_msi_rdy, output, 1 bit: request accepted when high together with i_msi_vld.
REQ-012 SHALL have port i_msi_hart_id, input, NR_HARTS_WIDTH bits: target hart.
REQ-013 SHALL have port i_msi_file, input, INTP_FILE_WIDTH bits: target file (0 = M, 1 = S, 2.. = VS).
REQ-014 SHALL have port i_msi_setipnum, input, NR_SRC_WIDTH bits: interrupt identity.
REQ-015 SHALL have port o_msi_info, output, MSI_INFO_WIDTH bits, packed {hart_id, file, setipnum} with setipnum in the LSBs.
REQ-016 SHALL have port o_msi_info_vld, output, 1 bit: registered pulse-level strobe to the cross-domain receiver.
REQ-017 SHALL have port o_busy, output, 1 bit: high when the FSM is not IDLE or the FIFO is non-empty.
REQ-018 SHALL have port o_drop_cnt, output, 8 bits: saturating count of filtered requests.

Function
REQ-019 An accepted request with setipnum == 0, setipnum >= NR_SRC, or file >= NR_INTP_FILES SHALL be dropped: it is not queued, and o_drop_cnt increments, saturating at 255.
REQ-020 o_msi_rdy SHALL be high when the FIFO is not full; dropped requests SHALL still be handshaken.
REQ-021 The FSM SHALL have three states: IDLE, HIGH and GUARD, with a down-counter sized for max(VLD_HIGH_CYCLES, VLD_GUARD_CYCLES).
REQ-022 In IDLE with the FIFO non-empty, the FSM SHALL pop the head, register it into o_msi_info, set o_msi_info_vld, load the counter with VLD_HIGH_CYCLES-1, and go to HIGH.
REQ-023 In HIGH, when the counter reaches 0, the FSM SHALL clear o_msi_info_vld, load the counter with VLD_GUARD_CYCLES-1, and go to GUARD; o_msi_info SHALL be unchanged.
REQ-024 In GUARD, when the counter reaches 0, the FSM SHALL behave as IDLE in the same cycle: pop and return to HIGH if the FIFO is non-empty, otherwise go to IDLE.
REQ-025 o_msi_info SHALL change only on the edge where o_msi_info_vld rises.
REQ-026 Latency: a valid request accepted at edge t into an empty FIFO with the FSM in IDLE SHALL produce o_msi_info_vld high at edge t+2.
REQ-027 Throughput SHALL be one MSI per VLD_HIGH_CYCLES + VLD_GUARD_CYCLES cycles.
REQ-028 A push and a pop in the same cycle SHALL both take effect, including when the FIFO is full.
REQ-029 Requests SHALL be delivered in acceptance order with no duplication.

Reset
REQ-030 While rst is high, o_msi_info_vld, o_msi_info, o_drop_cnt and o_busy SHALL be 0, o_msi_rdy SHALL be 0, the FSM SHALL be IDLE, and the FIFO SHALL be empty.
REQ-031 Reset mid-transfer SHALL force o_msi_info to 0 asynchronously, so any falling-edge capture by the receiver sees setipnum 0 and is ignored.
REQ-032 Queued requests SHALL be discarded on reset.

Configuration
REQ-033 With macro IMSIC_MSI_TX_FIFO_EN defined, the block SHALL use a FIFO_DEPTH-entry queue.
REQ-034 With IMSIC_MSI_TX_FIFO_EN undefined, the block SHALL use no FIFO: o_msi_rdy SHALL be high only in IDLE, and an accepted valid request SHALL load o_msi_info directly, raising o_msi_info_vld at edge t+1.

Structure
REQ-035 The shared package imsic_pkg SHALL hold the FSM state enum and the MSI_INFO field-offset constants (SETIPNUM_LSB, FILE_LSB, HART_LSB), shared with the receiver.
REQ-036 The queue SHALL be the sub-module imsic_msi_tx_fifo (synchronous, first-word not fall-through, full/empty flags), instantiated only under IMSIC_MSI_TX_FIFO_EN.

Verification
REQ-037 Single request {hart 1, file 1, setipnum 5} -> o_msi_info = 10'b01_001_00101; vld high 4 cycles, then info held 8 more cycles; o_busy returns to 0.
REQ-038 Push 5 valid requests back-to-back with depth 4 -> o_msi_rdy low exactly while the FIFO is full; all 5 emitted in order, each 12 cycles apart.
REQ-039 Requests with setipnum 0, then file 7, then a valid one -> o_drop_cnt = 2 and only the valid MSI is emitted; 300 drops -> o_drop_cnt = 255.
REQ-040 Assert rst during HIGH -> o_msi_info_vld and o_msi_info are 0 immediately; the FIFO is empty; the next request is emitted normally.
REQ-041 Back-to-back GUARD-to-HIGH -> o_msi_info never changes while vld is low within the guard window.
REQ-042 Build without IMSIC_MSI_TX_FIFO_EN -> o_msi_rdy drops during HIGH and GUARD; latency is 1 cycle.
